pipelined_logic_unit: RTL and testbench

Parametrised, elastic successor to the single-bit registered three-input OR cell. Applies an operator chosen per transaction to three WIDTH-bit operands, bitwise. The result goes through a STAGES-deep valid/ready pipeline with full backpressure. Sits between datapath producers and consumers that need a registered, stallable logic stage.

---
 rtl/pipelined_logic_unit.sv | 74 +++++++
 tb/tb_pipelined_logic_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_logic_unit.sv
// Per-transaction selectable bitwise 3-operand logic op feeding a STAGES-deep elastic valid/ready pipeline.
// Latency STAGES cycles; full backpressure, combinational ready chain, bubbles compress so all stages can fill.
module pipelined_logic_unit #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            a,
    input  logic [WIDTH-1:0]            b,
    input  logic [WIDTH-1:0]            c,
    input  logic [2:0]                  op,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            q,
    output logic [$clog2(STAGES+1)-1:0] count
);
    localparam int CW = $clog2(STAGES + 1);

    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  d [STAGES];
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  result;

    always_comb begin
        result = '0;
        case (op)
            3'd0: result = a | b | c;
            3'd1: result = a & b & c;
            3'd2: result = a ^ b ^ c;
            3'd3: result = (a & b) | (a & c) | (b & c);
            3'd4: result = (a & b) | c;
            3'd5: result = ~(a | b | c);
            3'd6: result = a;
            3'd7: result = (c & b) | (~c & a);
            default: result = '0;
        endcase
    end

    // A stage may load when the output is being consumed or any stage from it to the tail is empty;
    // written in closed form so no bit of adv depends on another.
    for (genvar k = 0; k < STAGES; k++) begin : g_adv
        assign adv[k] = out_ready | ~(&v[STAGES-1:k]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            for (int k = 0; k < STAGES; k++) d[k] <= '0;
        end else begin
            if (adv[0]) begin
                v[0] <= in_valid;
                if (in_valid) d[0] <= result;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) d[k] <= d[k-1];
                end
            end
        end
    end

    always_comb begin
        count = '0;
        for (int k = 0; k < STAGES; k++) count = count + CW'(v[k]);
    end

    assign in_ready  = adv[0];
    assign out_valid = v[STAGES-1];
    assign q         = d[STAGES-1];
endmodule

// File: tb/tb_pipelined_logic_unit.sv
// Directed and randomized bench for pipelined_logic_unit with WIDTH=8, STAGES=2.
module tb_pipelined_logic_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b, c;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] q;
    logic [1:0] count;

    int total = 0;
    int bad   = 0;

    pipelined_logic_unit #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [2:0] o, input logic [7:0] xa,
                         input logic [7:0] xb, input logic [7:0] xc);
        in_valid = vld; op = o; a = xa; b = xb; c = xc;
    endtask

    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] xa,
                                         input logic [7:0] xb, input logic [7:0] xc);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            case (o)
                3'd0: r[i] = xa[i] || xb[i] || xc[i];
                3'd1: r[i] = xa[i] && xb[i] && xc[i];
                3'd2: r[i] = (xa[i] + xb[i] + xc[i]) % 2 == 1;
                3'd3: r[i] = (xa[i] + xb[i] + xc[i]) >= 2;
                3'd4: r[i] = (xa[i] && xb[i]) || xc[i];
                3'd5: r[i] = !(xa[i] || xb[i] || xc[i]);
                3'd6: r[i] = xa[i];
                default: r[i] = xc[i] ? xb[i] : xa[i];
            endcase
        end
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1; out_ready = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
        tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q: got %h want 00", q); end
        total++; if (count !== 2'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        reset = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0 || count !== 2'd0 || q !== 8'h00 || in_ready !== 1'b1) begin
            bad++; $display("FAIL idle_after_reset: got vld=%b cnt=%0d q=%h rdy=%b want 0 0 00 1",
                            out_valid, count, q, in_ready);
        end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        drive(1'b1, 3'd0, 8'h0F, 8'hF0, 8'h00);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lat_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early: got out_valid=%b want 0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1 || q !== 8'hFF) begin
            bad++; $display("FAIL lat_result: got vld=%b q=%h want 1 ff", out_valid, q);
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_after: got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_sweep();
        logic [2:0] ops [4];
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic [7:0] vc [4];
        logic [7:0] ex [4];
        ops = '{3'd2, 3'd3, 3'd5, 3'd7};
        va  = '{8'hAA, 8'hF0, 8'h00, 8'h00};
        vb  = '{8'hFF, 8'hCC, 8'h00, 8'hFF};
        vc  = '{8'h0F, 8'hAA, 8'h00, 8'h3C};
        ex  = '{8'h5A, 8'hE8, 8'hFF, 8'h3C};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1'b1, ops[i], va[i], vb[i], vc[i]);
            else in_valid = 1'b0;
            tick();
            if (i >= 1 && i <= 4) begin
                total++; if (out_valid !== 1'b1 || q !== ex[i-1]) begin
                    bad++; $display("FAIL sweep_%0d: got vld=%b q=%h want 1 %h", i-1, out_valid, q, ex[i-1]);
                end
            end else if (i == 5) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sweep_end: got out_valid=%b want 0", out_valid); end
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 8'hFF, 8'h0F, 8'h3C);
        tick();
        drive(1'b1, 3'd4, 8'hF0, 8'h3C, 8'h01);
        tick();
        drive(1'b1, 3'd6, 8'hA5, 8'h00, 8'hFF);
        #1;
        total++; if (count !== 2'd2 || in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_full: got cnt=%0d rdy=%b want 2 0", count, in_ready);
        end
        tick();
        total++; if (count !== 2'd2 || out_valid !== 1'b1 || q !== 8'h0C) begin
            bad++; $display("FAIL bp_stall: got cnt=%0d vld=%b q=%h want 2 1 0c", count, out_valid, q);
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_rise: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || q !== 8'h31 || count !== 2'd2) begin
            bad++; $display("FAIL bp_second: got vld=%b q=%h cnt=%0d want 1 31 2", out_valid, q, count);
        end
        tick();
        total++; if (out_valid !== 1'b1 || q !== 8'hA5) begin
            bad++; $display("FAIL bp_third: got vld=%b q=%h want 1 a5", out_valid, q);
        end
        tick();
        total++; if (out_valid !== 1'b0 || count !== 2'd0) begin
            bad++; $display("FAIL bp_empty: got vld=%b cnt=%0d want 0 0", out_valid, count);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 8'h11, 8'h22, 8'h44);
        tick();
        drive(1'b1, 3'd2, 8'h01, 8'h02, 8'h04);
        tick();
        total++; if (count !== 2'd2 || out_valid !== 1'b1 || q !== 8'h77) begin
            bad++; $display("FAIL rm_before: got cnt=%0d vld=%b q=%h want 2 1 77", count, out_valid, q);
        end
        reset = 1'b1;
        drive(1'b1, 3'd6, 8'h99, 8'h00, 8'h00);
        tick();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        total++; if (out_valid !== 1'b0 || count !== 2'd0 || q !== 8'h00) begin
            bad++; $display("FAIL rm_after: got vld=%b cnt=%0d q=%h want 0 0 00", out_valid, count, q);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_ghost_%0d: got out_valid=%b q=%h want 0", i, out_valid, q); end
        end
    endtask

    task automatic test_stress();
        logic [7:0] exp_q [$];
        logic [7:0] want;
        for (int cyc = 0; cyc < 10000 + 8; cyc++) begin
            if (cyc < 10000) begin
                drive($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                out_ready = $urandom_range(0, 1) == 1;
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            #1;
            total++; if (int'(count) != exp_q.size() || count > 2'd2) begin
                bad++; $display("FAIL stress_count @%0d: got %0d want %0d", cyc, count, exp_q.size());
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL stress_dup @%0d: got q=%h want no output", cyc, q);
                end else begin
                    want = exp_q.pop_front();
                    if (q !== want) begin bad++; $display("FAIL stress_data @%0d: got %h want %h", cyc, q, want); end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(op, a, b, c));
            tick();
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stress_loss: got %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sweep();
        test_backpressure();
        test_reset_mid();
        test_stress();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
